// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} arb_state_e;

    localparam int unsigned MAX_LEN = 8;

    localparam logic SRC_DBG = 1'b0;
    localparam logic SRC_CHK = 1'b1;

endpackage

// File: rtl/uart_req_slot.sv
// Pending request slot: latches payload and clamped length, flags overruns.
module uart_req_slot
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              take_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [LEN_W-1:0]  len_o,
    output logic              overrun_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  len_clamped;

    always_comb begin
        len_clamped = len_i;
        if (len_i == '0 || len_i > LEN_W'(MAX_LEN)) begin
            len_clamped = LEN_W'(MAX_LEN);
        end
    end

    // A request landing in the same cycle the slot is granted refills it without loss.
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        len_d     = len_q;
        overrun_o = 1'b0;
        if (req_i) begin
            valid_d   = 1'b1;
            data_d    = data_i;
            len_d     = len_clamped;
            overrun_o = valid_q && !take_i;
        end else if (take_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            len_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            len_q   <= len_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign len_o   = len_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit engine between the debug dump and check-response sources.
// Define UART_ARB_RR_EN for round-robin arbitration; default is check-over-debug priority.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              dbg_req_i,
    input  logic [DATA_W-1:0] dbg_data_i,
    input  logic [LEN_W-1:0]  dbg_len_i,
    input  logic              chk_req_i,
    input  logic [DATA_W-1:0] chk_data_i,
    input  logic [LEN_W-1:0]  chk_len_i,
    input  logic              tx_done_i,
    output logic              tx_start_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic [LEN_W-1:0]  tx_len_o,
    output logic              busy_o,
    output logic              grant_chk_o,
    output logic [7:0]        drop_cnt_o
);

    arb_state_e        state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [LEN_W-1:0]  tx_len_q, tx_len_d;
    logic              grant_chk_q, grant_chk_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic [8:0]        drop_sum;

    logic [1:0]        slot_valid, slot_take, slot_ovr;
    logic [DATA_W-1:0] slot_data [2];
    logic [LEN_W-1:0]  slot_len [2];
    logic              sel_chk;
    logic              grant;

    uart_req_slot #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_slot_dbg (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (dbg_req_i),
        .data_i    (dbg_data_i),
        .len_i     (dbg_len_i),
        .take_i    (slot_take[SRC_DBG]),
        .valid_o   (slot_valid[SRC_DBG]),
        .data_o    (slot_data[SRC_DBG]),
        .len_o     (slot_len[SRC_DBG]),
        .overrun_o (slot_ovr[SRC_DBG])
    );

    uart_req_slot #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_slot_chk (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (chk_req_i),
        .data_i    (chk_data_i),
        .len_i     (chk_len_i),
        .take_i    (slot_take[SRC_CHK]),
        .valid_o   (slot_valid[SRC_CHK]),
        .data_o    (slot_data[SRC_CHK]),
        .len_o     (slot_len[SRC_CHK]),
        .overrun_o (slot_ovr[SRC_CHK])
    );

    assign grant = (state_q == IDLE) && (|slot_valid);

`ifdef UART_ARB_RR_EN
    // Remembers the previous winner; resets to debug so the first tie goes to check.
    logic last_chk_q, last_chk_d;

    assign sel_chk    = slot_valid[SRC_CHK] && (!slot_valid[SRC_DBG] || !last_chk_q);
    assign last_chk_d = grant ? sel_chk : last_chk_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_chk_q <= 1'b0;
        end else begin
            last_chk_q <= last_chk_d;
        end
    end
`else
    assign sel_chk = slot_valid[SRC_CHK];
`endif

    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_len_d    = tx_len_q;
        grant_chk_d = grant_chk_q;
        slot_take   = '0;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d            = START;
                    slot_take[SRC_CHK] = sel_chk;
                    slot_take[SRC_DBG] = !sel_chk;
                    tx_data_d          = sel_chk ? slot_data[SRC_CHK] : slot_data[SRC_DBG];
                    tx_len_d           = sel_chk ? slot_len[SRC_CHK] : slot_len[SRC_DBG];
                    grant_chk_d        = sel_chk;
                end
            end
            START:   state_d = WAIT;
            WAIT:    if (tx_done_i) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + 9'(slot_ovr[SRC_DBG]) + 9'(slot_ovr[SRC_CHK]);
        drop_cnt_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            tx_data_q   <= '0;
            tx_len_q    <= '0;
            grant_chk_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_len_q    <= tx_len_d;
            grant_chk_q <= grant_chk_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign tx_start_o  = (state_q == START);
    assign busy_o      = (state_q == START) || (state_q == WAIT);
    assign tx_data_o   = tx_data_q;
    assign tx_len_o    = tx_len_q;
    assign grant_chk_o = grant_chk_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit engine between two requesters: the CPU debug dump (64-bit word on each MIPS clock edge) and the receive-side check response (64-bit status after each received byte). It latches requests, selects one, and issues a one-cycle start pulse with stable data and length to the transmit engine. It then holds that data until the engine reports completion. It sits between the request sources and the transmit engine, and runs on the UART-side clock.

## Interface
- `DATA_W`, 64: payload width per request.
- `LEN_W`, 4: byte-count width; legal counts are 1..8.
- `clk` input 1: UART-side clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `dbg_req` input 1: one-cycle pulse; debug word available.
- `dbg_data` input DATA_W: debug payload; sampled only when `dbg_req`=1.
- `dbg_len` input LEN_W: debug byte count; sampled with `dbg_req`.
- `chk_req` input 1: one-cycle pulse; check-response available.
- `chk_data` input DATA_W: check payload; sampled with `chk_req`.
- `chk_len` input LEN_W: check byte count; sampled with `chk_req`.
- `tx_done` input 1: one-cycle pulse from the engine; current frame finished.
- `tx_start` output 1: one-cycle start pulse to the engine.
- `tx_data` output DATA_W: payload to the engine; stable from `tx_start` until `tx_done`.
- `tx_len` output LEN_W: byte count to the engine; stable over the same window.
- `busy` output 1: a frame is in flight (START or WAIT).
- `grant_chk` output 1: the in-flight frame belongs to the check source.
- `drop_cnt` output 8: saturating count of requests lost to overrun.

## Operation
- Each source has a pending slot: a valid bit plus latched data and length.
- A request pulse loads its slot.
- Overrun: a request arriving while its own slot is still valid overwrites data and length, and `drop_cnt` increments, saturating at 255.
- Length 0 is clamped to 8 when latched. Lengths above 8 are also clamped to 8.
- FSM states:
  - IDLE → START when either slot is valid. The winner's slot is copied into `tx_data`/`tx_len`, its valid bit clears, and `grant_chk` is set.
  - START → WAIT unconditionally. `tx_start`=1 only in START.
  - WAIT → GAP on `tx_done`.
  - GAP → IDLE unconditionally. GAP is a one-cycle idle line guard.
- Selection, default fixed priority: check source wins over debug.
- Simultaneous events:
  - A request that arrives in the same cycle its slot is granted loads a fresh slot. This is not counted as a drop.
  - Both requests in the same cycle: both slots load and the winner is chosen at the next IDLE evaluation.
- `tx_done` outside WAIT is ignored.
- Reset at any time clears all outputs and slots immediately. The FSM returns to IDLE; a frame in flight is abandoned.

## Timing
- Reset values:
  - `tx_start`=0, `busy`=0, `grant_chk`=0, `drop_cnt`=0.
  - `tx_data`=0, `tx_len`=0.
  - Both slots invalid; FSM in IDLE.
- Latency, idle arbiter: request high in cycle c → slot valid in c+1 → `tx_start` high in cycle c+2.
- `busy` is high from the START cycle through the WAIT cycle that sees `tx_done`. It is low in GAP.
- Minimum back-to-back spacing: `tx_done` in cycle d → next `tx_start` no earlier than d+3.

## Configuration
- `UART_ARB_RR_EN` defined: round-robin arbitration.
  - A last-grant bit records the previous winner.
  - When both slots are valid, the source not granted last wins.
  - The last-grant bit resets to "debug", so the first tie goes to check.
- `UART_ARB_RR_EN` undefined: fixed priority, check over debug. The last-grant bit is not built.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (`IDLE`, `START`, `WAIT`, `GAP`).
  - `MAX_LEN`=8.
  - Source-index constants (`SRC_DBG`=0, `SRC_CHK`=1).
- Sub-module `uart_req_slot`, instantiated twice:
  - Holds valid, data and length; performs the length clamp.
  - Outputs an overrun pulse that feeds the shared `drop_cnt` logic.

## Test plan
- Single request: `dbg_req` with data 0x0123_4567_89AB_CDEF, len 8 → `tx_start` two cycles later with that data and len 8; `busy`=1 until `tx_done`; `grant_chk`=0.
- Simultaneous requests:
  - Stimulus: `dbg_req` and `chk_req` in the same cycle.
  - Without the macro: check frame is sent first, then the debug frame, with `tx_start` 3 cycles after the first `tx_done`.
  - With `UART_ARB_RR_EN`: same order on the first tie; a second tie after a check grant picks debug.
- Overrun: three `dbg_req` pulses while busy with a check frame → one debug frame carrying the last data is sent; `drop_cnt`=2.
- Length clamp: `chk_len`=0, then `chk_len`=12 → `tx_len`=8 for both frames.
- Reset mid-frame: `rst_n` low during WAIT with the debug slot pending → all outputs 0 and no `tx_start` after release. A later `tx_done` pulse is ignored.
- Saturation: 300 overrun requests → `drop_cnt` holds at 255.
